// File: rtl/err_stat_accum.sv
// -----------------------------------------------------------------------------
// err_stat_accum
//
// Purpose:
//   Measures the error statistics of an N-bit adder under test. A run starts
//   with a start pulse and collects a fixed number of samples. Each sample is
//   a pair of operands (a, b) and the sum s produced by the adder under test.
//   The block compares s against the exact sum a+b. It counts the samples and
//   the erroneous samples. It also tracks the largest error distance and
//   keeps a saturating sum of the error distances.
//
//   Pipeline:
//     stage 1 : register s and exact = a+b (N+1 bits)
//     stage 2 : register ed = |s-exact| (and the signed difference)
//     retire  : fold stage-2 results into the statistics
//   A sample accepted at edge t is visible in the statistics after edge t+2.
//   done rises one cycle after the last sample retires.
//
// Configuration macro:
//   ERR_BIAS_EN - when defined, bias_sum accumulates the signed error (s-exact)
//                 in two's complement, wrapping. When undefined, bias_sum is
//                 tied to 0 and no bias logic exists.
//
// Parameters:
//   N      operand width of the adder under test
//   CNT_W  width of the sample/error counters and of cfg_samples
//   ACC_W  width of the error-distance accumulator
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   pulse, begins a run (honoured in IDLE/DONE only)
//   clear        in   synchronous abort and zero, wins over start
//   cfg_samples  in   samples per run, latched on an accepted start
//   in_valid     in   sample present
//   in_ready     out  sample accepted when in_valid && in_ready
//   a, b         in   operands
//   s            in   sum from the adder under test (N+1 bits)
//   busy         out  run in progress (RUN or DRAIN)
//   done         out  run complete, results stable
//   samp_cnt     out  samples retired
//   err_cnt      out  samples with s != a+b
//   max_ed       out  largest |s-(a+b)|
//   sum_ed       out  accumulated |s-(a+b)|, saturating
//   sat          out  sum_ed has saturated
//   bias_sum     out  signed sum of s-(a+b) (0 unless ERR_BIAS_EN)
// -----------------------------------------------------------------------------
module err_stat_accum #(
  parameter int N     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] cfg_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N:0]       s,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] samp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N:0]       max_ed,
  output logic [ACC_W-1:0] sum_ed,
  output logic             sat,
  output logic [ACC_W-1:0] bias_sum
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic [1:0]       stateReg;
  logic [CNT_W-1:0] cfgReg;
  logic [CNT_W-1:0] acceptCnt;

  logic             accept;
  logic             lastAccept;
  logic             startOk;
  logic             pipeEmpty;

  logic             s1Valid;
  logic             s2Valid;

  assign in_ready   = (stateReg == RUN) && (acceptCnt < cfgReg);
  assign accept     = in_valid && in_ready;
  assign lastAccept = accept && ((acceptCnt + CNT_W'(1)) == cfgReg);
  // clear outranks start everywhere, so fold it into the start qualifier.
  assign startOk    = start && !clear && ((stateReg == IDLE) || (stateReg == DONE));
  assign pipeEmpty  = !s1Valid && !s2Valid;

  assign busy = (stateReg == RUN) || (stateReg == DRAIN);
  assign done = (stateReg == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      cfgReg    <= '0;
      acceptCnt <= '0;
    end else if (clear) begin
      stateReg  <= IDLE;
      acceptCnt <= '0;
    end else begin
      case (stateReg)
        IDLE, DONE: begin
          if (startOk) begin
            cfgReg    <= cfg_samples;
            acceptCnt <= '0;
            // An empty run has nothing to collect: finish at once.
            stateReg  <= (cfg_samples == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            acceptCnt <= acceptCnt + CNT_W'(1);
            if (lastAccept) begin
              stateReg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // No new samples enter in DRAIN, so an empty pipeline means the
          // final sample has already been folded into the statistics.
          if (pipeEmpty) begin
            stateReg <= DONE;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture the observed sum and the exact reference sum.
  // The operands are only needed to build exact, so they are folded into it
  // at capture time instead of being carried separately.
  // ---------------------------------------------------------------------------
  logic [N:0] exactComb;
  logic [N:0] s1S;
  logic [N:0] s1Exact;

  assign exactComb = {1'b0, a} + {1'b0, b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s1S     <= '0;
      s1Exact <= '0;
    end else if (clear || startOk) begin
      s1Valid <= 1'b0;
    end else begin
      s1Valid <= accept;
      if (accept) begin
        s1S     <= s;
        s1Exact <= exactComb;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: error distance (and signed error when bias tracking is built).
  // ---------------------------------------------------------------------------
  logic [N:0] edComb;
  logic [N:0] s2Ed;

  // Subtract the smaller from the larger so the magnitude never wraps.
  assign edComb = (s1S >= s1Exact) ? (s1S - s1Exact) : (s1Exact - s1S);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid <= 1'b0;
      s2Ed    <= '0;
    end else if (clear || startOk) begin
      s2Valid <= 1'b0;
    end else begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Ed <= edComb;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] sampReg;
  logic [CNT_W-1:0] errReg;
  logic [N:0]       maxReg;
  logic [ACC_W-1:0] sumReg;
  logic             satReg;

  // One extra bit catches the carry that signals saturation.
  logic [ACC_W:0]   sumWide;
  assign sumWide = {1'b0, sumReg} + (ACC_W+1)'(s2Ed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sampReg <= '0;
      errReg  <= '0;
      maxReg  <= '0;
      sumReg  <= '0;
      satReg  <= 1'b0;
    end else if (clear || startOk) begin
      sampReg <= '0;
      errReg  <= '0;
      maxReg  <= '0;
      sumReg  <= '0;
      satReg  <= 1'b0;
    end else if (s2Valid) begin
      sampReg <= sampReg + CNT_W'(1);
      if (s2Ed != '0) begin
        errReg <= errReg + CNT_W'(1);
      end
      if (s2Ed > maxReg) begin
        maxReg <= s2Ed;
      end
      if (sumWide[ACC_W]) begin
        sumReg <= '1;
        satReg <= 1'b1;
      end else begin
        sumReg <= sumWide[ACC_W-1:0];
      end
    end
  end

  assign samp_cnt = sampReg;
  assign err_cnt  = errReg;
  assign max_ed   = maxReg;
  assign sum_ed   = sumReg;
  assign sat      = satReg;

  // ---------------------------------------------------------------------------
  // Optional signed bias accumulator
  // ---------------------------------------------------------------------------
`ifdef ERR_BIAS_EN
  // One bit wider than s so the signed difference of two N+1-bit values fits.
  logic signed [N+1:0] diffComb;
  logic signed [N+1:0] s2Diff;
  logic [ACC_W-1:0]    biasReg;

  assign diffComb = $signed({1'b0, s1S}) - $signed({1'b0, s1Exact});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Diff <= '0;
    end else if (s1Valid && !clear && !startOk) begin
      s2Diff <= diffComb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      biasReg <= '0;
    end else if (clear || startOk) begin
      biasReg <= '0;
    end else if (s2Valid) begin
      // Sign-extending cast, then a plain wrapping add.
      biasReg <= biasReg + ACC_W'(s2Diff);
    end
  end

  assign bias_sum = biasReg;
`else
  assign bias_sum = '0;
`endif

endmodule
